// File: rtl/shift_arbiter_pkg.sv
// Shared encodings and widths for the two-requester shift arbiter.
package shift_arbiter_pkg;
  localparam int RES_W = 32;
  localparam int CNT_W = 16;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  typedef struct packed {
    logic [RES_W-1:0] data;
    logic             id;
    logic             err;
  } rsp_t;
endpackage

// File: rtl/shift_arbiter_shift_core.sv
// Shared 32-bit shifter: sll/srl/sra units plus op-select mux.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Reserved op passes the operand through and flags err.
module sll32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = a << shamt;
endmodule

module srl32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = a >> shamt;
endmodule

module sra32 (
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic [31:0] y
);
  assign y = $unsigned($signed(a) >>> shamt);
endmodule

module shift_core
  import shift_arbiter_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [4:0]       shamt,
  input  logic [1:0]       op,
  output logic [RES_W-1:0] y,
  output logic             err
);
  logic [RES_W-1:0] y_sll, y_srl, y_sra;

  sll32 u_sll (.a(a), .shamt(shamt), .y(y_sll));
  srl32 u_srl (.a(a), .shamt(shamt), .y(y_srl));
  sra32 u_sra (.a(a), .shamt(shamt), .y(y_sra));

  always_comb begin
    y   = a;
    err = 1'b0;
    case (op)
      OP_SLL:  y = y_sll;
      OP_SRL:  y = y_srl;
      OP_SRA:  y = y_sra;
      default: err = 1'b1;
    endcase
  end
endmodule

// File: rtl/shift_arbiter.sv
// Two-requester arbiter in front of one shifter and a one-entry result register.
// Latency: result valid one cycle after acceptance; one op per cycle sustained.
// Backpressure: readies drop while the result slot is held (rsp_valid & !rsp_ready).
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [RES_W-1:0] req0_a,
  input  logic [4:0]       req0_shamt,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [RES_W-1:0] req1_a,
  input  logic [4:0]       req1_shamt,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_id,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_cnt
);
  logic [0:0]       state;
  logic             last_grant;
  rsp_t             rsp_q;
  logic             slot_free, gnt0, gnt1, accept, sel1;
  logic [RES_W-1:0] core_a, core_y;
  logic [4:0]       core_shamt;
  logic [1:0]       core_op;
  logic             core_err;

  assign rsp_valid = (state == FULL);
  assign slot_free = !rsp_valid || rsp_ready;

  // On contention req1 wins only in round-robin mode when req0 went last.
  assign gnt1 = req1_valid && (!req0_valid || (RR_EN && !last_grant));
  assign gnt0 = req0_valid && !gnt1;

  assign req0_ready = rst_n && slot_free && gnt0;
  assign req1_ready = rst_n && slot_free && gnt1;
  assign accept     = req0_ready || req1_ready;
  assign sel1       = req1_ready;

  assign core_a     = sel1 ? req1_a     : req0_a;
  assign core_shamt = sel1 ? req1_shamt : req0_shamt;
  assign core_op    = sel1 ? req1_op    : req0_op;

  shift_core u_core (
    .a     (core_a),
    .shamt (core_shamt),
    .op    (core_op),
    .y     (core_y),
    .err   (core_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      last_grant <= 1'b1;
      rsp_q      <= '0;
      op_cnt     <= '0;
    end else begin
      if (accept) begin
        state      <= FULL;
        last_grant <= sel1;
        rsp_q      <= '{data: core_y, id: sel1, err: core_err};
        op_cnt     <= op_cnt + 1'b1;
      end else if (rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

  assign rsp_data = rsp_q.data;
  assign rsp_id   = rsp_q.id;
  assign rsp_err  = rsp_q.err;
endmodule
